// File: rtl/gerenciador_escrita_anterior_pkg.sv
// Shared definitions for the predecessor-memory write manager.
//   - ESTADO_* : 2-bit encodings of the manager FSM states
//   - estado_t : enum view of the same encodings
//   - largura_entrada() : FIFO entry width, vertex + predecessor (2*ADDR_WIDTH)
package gerenciador_escrita_anterior_pkg;

  localparam logic [1:0] ESTADO_OCIOSO   = 2'd0;
  localparam logic [1:0] ESTADO_LIMPANDO = 2'd1;
  localparam logic [1:0] ESTADO_ATIVO    = 2'd2;

  typedef enum logic [1:0] {
    OCIOSO   = ESTADO_OCIOSO,
    LIMPANDO = ESTADO_LIMPANDO,
    ATIVO    = ESTADO_ATIVO
  } estado_t;

  // Width of one buffered relaxation: {vertice, anterior}.
  function automatic int largura_entrada(input int addr_width);
    return 2 * addr_width;
  endfunction

endpackage

// File: rtl/gerenciador_escrita_anterior_fifo_sincrona.sv
// fifo_sincrona: small synchronous FIFO with combinational head data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry (ignored when full)
//   pop             discard head entry (ignored when empty)
//   flush           empty the FIFO; wins over push/pop
//   head_data       current head entry, valid while !empty
//   full, empty     status flags
// Pointers carry one extra MSB so that full and empty are distinguishable.
module fifo_sincrona
  import gerenciador_escrita_anterior_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]          wr_ptr_reg;
  logic [PTR_W:0]          rd_ptr_reg;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/gerenciador_escrita_anterior.sv
// gerenciador_escrita_anterior: write-side manager of the predecessor RAM.
// Clears every entry to "own predecessor" (addr=data=vertex), then buffers
// relaxation results and writes them to the RAM, one per cycle.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   inicio_in                      start/restart pulse (samples the two below)
//   top_fonte_in, ultimo_vertice_in source vertex, last vertex to clear
//   relax_valid_in/_vertice_in/_anterior_in, relax_ready_out  relaxation input
//   write_en_out/_addr_out/_data_out  registered RAM write port
//   pronto_out                     clearing done (ATIVO)
//   ocioso_out                     ATIVO with nothing buffered or in flight
// Optional feature: define ESCRITA_ANTERIOR_DESCARTE_FONTE_EN to drop
// relaxations that target the source vertex (keeps its self-loop intact).
module gerenciador_escrita_anterior
  import gerenciador_escrita_anterior_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio_in,
  input  logic [ADDR_WIDTH-1:0] top_fonte_in,
  input  logic [ADDR_WIDTH-1:0] ultimo_vertice_in,
  input  logic                  relax_valid_in,
  input  logic [ADDR_WIDTH-1:0] relax_vertice_in,
  input  logic [ADDR_WIDTH-1:0] relax_anterior_in,
  output logic                  relax_ready_out,
  output logic                  write_en_out,
  output logic [ADDR_WIDTH-1:0] write_addr_out,
  output logic [ADDR_WIDTH-1:0] write_data_out,
  output logic                  pronto_out,
  output logic                  ocioso_out
);

  localparam int ENTRADA_W = largura_entrada(ADDR_WIDTH);

`ifdef ESCRITA_ANTERIOR_DESCARTE_FONTE_EN
  localparam bit FILTRO_FONTE = 1'b1;
`else
  localparam bit FILTRO_FONTE = 1'b0;
`endif

  estado_t               estado_reg, estado_next;
  logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;      // extra bit: last address 2^W-1 ends cleanly
  logic [ADDR_WIDTH-1:0] fonte_reg, fonte_next;
  logic [ADDR_WIDTH-1:0] ultimo_reg, ultimo_next;
  logic                  write_en_reg, write_en_next;
  logic [ADDR_WIDTH-1:0] write_addr_reg, write_addr_next;
  logic [ADDR_WIDTH-1:0] write_data_reg, write_data_next;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [ENTRADA_W-1:0]  fifo_head;
  logic                  eh_fonte;

  // A start pulse drops ready so an entry offered alongside it is never
  // reported as accepted and then silently flushed.
  assign relax_ready_out = (estado_reg == ATIVO) && !fifo_full && !inicio_in;
  assign eh_fonte        = (relax_vertice_in == fonte_reg);
  assign fifo_push       = relax_valid_in && relax_ready_out && !(FILTRO_FONTE && eh_fonte);

  fifo_sincrona #(
    .DATA_WIDTH (ENTRADA_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({relax_vertice_in, relax_anterior_in}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg     <= OCIOSO;
      cnt_reg        <= '0;
      fonte_reg      <= '0;
      ultimo_reg     <= '0;
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
    end else begin
      estado_reg     <= estado_next;
      cnt_reg        <= cnt_next;
      fonte_reg      <= fonte_next;
      ultimo_reg     <= ultimo_next;
      write_en_reg   <= write_en_next;
      write_addr_reg <= write_addr_next;
      write_data_reg <= write_data_next;
    end
  end

  always_comb begin
    estado_next     = estado_reg;
    cnt_next        = cnt_reg;
    fonte_next      = fonte_reg;
    ultimo_next     = ultimo_reg;
    write_en_next   = 1'b0;
    write_addr_next = write_addr_reg;
    write_data_next = write_data_reg;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;

    if (inicio_in) begin
      // Restart beats any push/pop in the same cycle.
      estado_next = LIMPANDO;
      cnt_next    = '0;
      fonte_next  = top_fonte_in;
      ultimo_next = ultimo_vertice_in;
      fifo_flush  = 1'b1;
    end else begin
      case (estado_reg)
        LIMPANDO: begin
          write_en_next   = 1'b1;
          write_addr_next = cnt_reg[ADDR_WIDTH-1:0];
          write_data_next = cnt_reg[ADDR_WIDTH-1:0];
          if (cnt_reg == {1'b0, ultimo_reg}) estado_next = ATIVO;
          else                               cnt_next    = cnt_reg + 1'b1;
        end
        ATIVO: begin
          if (!fifo_empty) begin
            fifo_pop        = 1'b1;
            write_en_next   = 1'b1;
            write_addr_next = fifo_head[ENTRADA_W-1:ADDR_WIDTH];
            write_data_next = fifo_head[ADDR_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign write_en_out   = write_en_reg;
  assign write_addr_out = write_addr_reg;
  assign write_data_out = write_data_reg;
  assign pronto_out     = (estado_reg == ATIVO);
  assign ocioso_out     = (estado_reg == ATIVO) && fifo_empty && !write_en_reg;

endmodule

// File: tb/tb_gerenciador_escrita_anterior.sv
// Self-checking bench for gerenciador_escrita_anterior. Expected RAM writes
// are queued by the stimulus; a monitor pops and compares on every
// write_en_out. A standalone fifo_sincrona instance exercises full/empty,
// since the manager pops as fast as it accepts and cannot fill its FIFO.
module tb_gerenciador_escrita_anterior;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inicio_in;
  logic [AW-1:0] top_fonte_in, ultimo_vertice_in;
  logic          relax_valid_in;
  logic [AW-1:0] relax_vertice_in, relax_anterior_in;
  logic          relax_ready_out, write_en_out, pronto_out, ocioso_out;
  logic [AW-1:0] write_addr_out, write_data_out;

  logic       f_push, f_pop, f_flush, f_full, f_empty;
  logic [7:0] f_din, f_head;

  int checks = 0;
  int errors = 0;
  logic [2*AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  gerenciador_escrita_anterior #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inicio_in         (inicio_in),
    .top_fonte_in      (top_fonte_in),
    .ultimo_vertice_in (ultimo_vertice_in),
    .relax_valid_in    (relax_valid_in),
    .relax_vertice_in  (relax_vertice_in),
    .relax_anterior_in (relax_anterior_in),
    .relax_ready_out   (relax_ready_out),
    .write_en_out      (write_en_out),
    .write_addr_out    (write_addr_out),
    .write_data_out    (write_data_out),
    .pronto_out        (pronto_out),
    .ocioso_out        (ocioso_out)
  );

  fifo_sincrona #(.DATA_WIDTH(8), .DEPTH(4)) u_fifo_tb (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (f_push),
    .push_data (f_din),
    .pop       (f_pop),
    .flush     (f_flush),
    .head_data (f_head),
    .full      (f_full),
    .empty     (f_empty)
  );

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_en_out === 1'b1) begin
      $display("write addr=%0d data=%0d", write_addr_out, write_data_out);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected none", write_addr_out, write_data_out);
      end else begin
        chk("write", {12'd0, write_addr_out, write_data_out}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ocioso(input int limite);
    for (int i = 0; i < limite; i++) begin
      @(negedge clk);
      if (ocioso_out) break;
    end
    chk("ocioso_timeout", {31'd0, ocioso_out}, 32'd1);
    chk("pronto", {31'd0, pronto_out}, 32'd1);
    chk("fila_vazia", exp_q.size(), 32'd0);
    tick();
  endtask

  task automatic sweep(input int ultimo);
    for (int i = 0; i <= ultimo; i++) exp_q.push_back({AW'(i), AW'(i)});
    top_fonte_in      = AW'(3);
    ultimo_vertice_in = AW'(ultimo);
    inicio_in         = 1'b1;
    tick();
    inicio_in = 1'b0;
    wait_ocioso(ultimo + 10);
  endtask

  task automatic relax(input int v, input int a, input bit espera_escrita);
    relax_valid_in    = 1'b1;
    relax_vertice_in  = AW'(v);
    relax_anterior_in = AW'(a);
    if (espera_escrita) exp_q.push_back({AW'(v), AW'(a)});
    @(negedge clk);
    chk("ready_ativo", {31'd0, relax_ready_out}, 32'd1);
    tick();
    relax_valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inicio_in = 1'b0; relax_valid_in = 1'b0;
    top_fonte_in = '0; ultimo_vertice_in = '0; relax_vertice_in = '0; relax_anterior_in = '0;
    f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_din = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {8'd0, relax_ready_out, write_en_out, write_addr_out, write_data_out, pronto_out, ocioso_out}, 32'd0);
    end
    tick();
    rst_n = 1'b1;

    // FIFO sub-module: fill, no push-through when full, order, flush
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1; f_din = 8'(10 + i);
      tick();
    end
    f_push = 1'b0;
    chk("fifo_full", {31'd0, f_full}, 32'd1);
    f_push = 1'b1; f_din = 8'd99; f_pop = 1'b1;
    tick();
    f_push = 1'b0; f_pop = 1'b0;
    chk("fifo_not_full_after_pop", {31'd0, f_full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fifo_head", {24'd0, f_head}, 32'(11 + i));
      f_pop = 1'b1;
      tick();
      f_pop = 1'b0;
    end
    chk("fifo_empty", {31'd0, f_empty}, 32'd1);
    f_push = 1'b1; f_din = 8'd5;
    tick();
    f_push = 1'b0; f_flush = 1'b1;
    tick();
    f_flush = 1'b0;
    chk("fifo_flush", {31'd0, f_empty}, 32'd1);

    // Idle after reset: no writes, all outputs low
    repeat (10) begin
      @(negedge clk);
      chk("idle_outputs", {8'd0, relax_ready_out, write_en_out, write_addr_out, write_data_out, pronto_out, ocioso_out}, 32'd0);
    end
    tick();

    // Clear sweep 0..7 on consecutive cycles
    for (int i = 0; i <= 7; i++) exp_q.push_back({AW'(i), AW'(i)});
    top_fonte_in = AW'(3); ultimo_vertice_in = AW'(7); inicio_in = 1'b1;
    tick();
    inicio_in = 1'b0;
    @(negedge clk);
    chk("clear_first_latency", {29'd0, write_en_out, relax_ready_out, pronto_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clear_consecutive", {31'd0, write_en_out}, 32'd1);
    end
    @(negedge clk);
    chk("after_clear", {29'd0, write_en_out, pronto_out, ocioso_out}, 32'b011);
    tick();

    // Single relaxation and its latency
    relax_valid_in = 1'b1; relax_vertice_in = AW'(5); relax_anterior_in = AW'(2);
    exp_q.push_back({AW'(5), AW'(2)});
    tick();
    relax_valid_in = 1'b0;
    @(negedge clk);
    chk("relax_latency_0", {30'd0, write_en_out, ocioso_out}, 32'b00);
    @(negedge clk);
    chk("relax_latency_1", {31'd0, write_en_out}, 32'd1);
    @(negedge clk);
    chk("relax_ocioso_back", {30'd0, write_en_out, ocioso_out}, 32'b01);
    tick();

    // Sustained stream of 6 entries
    for (int i = 0; i < 6; i++) relax(20 + i, i + 1, 1'b1);
    wait_ocioso(20);

    // Restart with an entry pending: it must never be written
    relax_valid_in = 1'b1; relax_vertice_in = AW'(9); relax_anterior_in = AW'(9);
    tick();
    relax_valid_in = 1'b0;
    for (int i = 0; i <= 2; i++) exp_q.push_back({AW'(i), AW'(i)});
    top_fonte_in = AW'(3); ultimo_vertice_in = AW'(2); inicio_in = 1'b1;
    tick();
    inicio_in = 1'b0;
    wait_ocioso(20);

    // Source filter (source = 3)
`ifdef ESCRITA_ANTERIOR_DESCARTE_FONTE_EN
    relax(3, 1, 1'b0);
`else
    relax(3, 1, 1'b1);
`endif
    relax(4, 3, 1'b1);
    wait_ocioso(20);

    // Boundary sweeps: single vertex and full address range
    sweep(0);
    sweep((1 << AW) - 1);

    // Reset in the middle of a sweep abandons it
    for (int i = 0; i <= 7; i++) exp_q.push_back({AW'(i), AW'(i)});
    top_fonte_in = AW'(3); ultimo_vertice_in = AW'(7); inicio_in = 1'b1;
    tick();
    inicio_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_outputs", {8'd0, relax_ready_out, write_en_out, write_addr_out, write_data_out, pronto_out, ocioso_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("after_reset_idle", {29'd0, write_en_out, pronto_out, relax_ready_out}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
